pipeline_stall_ctrl: RTL and testbench

//  Consumes hazard requests (DataHazard from hazard detection, taken branch from EX, jump from ID,

---
 rtl/pipeline_stall_ctrl_if.sv | 34 +++
 rtl/pipeline_stall_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-request / pipeline-control bundle between the CPU datapath and pipeline_stall_ctrl.
// The master side raises requests; the slave side (the controller) drives enables, flushes and counters.
interface pipeline_stall_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             data_hazard;
   logic             branch_taken;
   logic             jump_id;
   logic             mem_busy;
   logic             wdog_clear;
   logic             cnt_clear;

   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_write;
   logic             halted;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;
   logic [CNT_W-1:0] bubble_count;

   modport master (
      output data_hazard, branch_taken, jump_id, mem_busy, wdog_clear, cnt_clear,
      input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, halted,
      input  stall_cycles, flush_count, bubble_count
   );

   modport slave (
      input  data_hazard, branch_taken, jump_id, mem_busy, wdog_clear, cnt_clear,
      output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, halted,
      output stall_cycles, flush_count, bubble_count
   );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: prioritised hazard resolution, memory-wait freeze,
// consecutive-stall watchdog and saturating performance counters.
module pipeline_stall_ctrl #(
   parameter int STALL_LIMIT = 64,
   parameter int CNT_W       = 32
) (
   input logic                  clk,
   input logic                  reset_n,
   pipeline_stall_ctrl_if.slave bus
);

   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam logic [SW-1:0] STREAK_TRIP = SW'(STALL_LIMIT - 1);
   localparam logic [SW-1:0] STREAK_SAT  = SW'(STALL_LIMIT);

   typedef enum logic [1:0] {RUN, FREEZE, HALT} state_e;

   state_e           state_q, state_d;
   logic             halted_q;
   logic [SW-1:0]    streak_q, streak_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic [CNT_W-1:0] bubble_q, bubble_d;

   logic pc_c, if_id_c, if_flush_c, id_flush_c, ex_mem_c;
   logic active;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign active = (state_q != HALT);

   // FREEZE shares RUN's table: held upstream stages re-present their requests once mem_busy drops.
   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      pc_c       = 1'b0;
      if_id_c    = 1'b0;
      if_flush_c = 1'b0;
      id_flush_c = 1'b0;
      ex_mem_c   = 1'b0;
      if (active && !bus.mem_busy) begin
         if (bus.branch_taken) begin
            pc_c       = 1'b1;
            if_id_c    = 1'b1;
            if_flush_c = 1'b1;
            id_flush_c = 1'b1;
            ex_mem_c   = 1'b1;
         end else if (bus.data_hazard) begin
            id_flush_c = 1'b1;
            ex_mem_c   = 1'b1;
         end else if (bus.jump_id) begin
            pc_c       = 1'b1;
            if_id_c    = 1'b1;
            if_flush_c = 1'b1;
            ex_mem_c   = 1'b1;
         end else begin
            pc_c       = 1'b1;
            if_id_c    = 1'b1;
            ex_mem_c   = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      if (!active) begin
         if (bus.wdog_clear) begin
            state_d  = RUN;
            streak_d = '0;
         end
      end else begin
         state_d = bus.mem_busy ? FREEZE : RUN;
         if (bus.wdog_clear || pc_c) begin
            streak_d = '0;
         end else begin
            if (streak_q >= STREAK_TRIP) state_d = HALT;
            streak_d = (streak_q == STREAK_SAT) ? STREAK_SAT : streak_q + 1'b1;
         end
      end
   end

   // Counters are frozen in HALT, but an explicit clear still takes effect.
   always_comb begin
      stall_d  = stall_q;
      flush_d  = flush_q;
      bubble_d = bubble_q;
      if (bus.cnt_clear) begin
         stall_d  = '0;
         flush_d  = '0;
         bubble_d = '0;
      end else if (active) begin
         if (!pc_c)                     stall_d  = sat_inc(stall_q);
         if (if_flush_c || id_flush_c)  flush_d  = sat_inc(flush_q);
         if (id_flush_c && !pc_c)       bubble_d = sat_inc(bubble_q);
      end
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values regardless of order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= RUN;
         halted_q <= 1'b0;
         streak_q <= '0;
         stall_q  <= '0;
         flush_q  <= '0;
         bubble_q <= '0;
      end else begin
         state_q  <= state_d;
         halted_q <= (state_d == HALT);
         streak_q <= streak_d;
         stall_q  <= stall_d;
         flush_q  <= flush_d;
         bubble_q <= bubble_d;
      end
   end

   // Gating with reset_n guarantees no enable or residual flush while reset is asserted.
   assign bus.pc_write     = reset_n & pc_c;
   assign bus.if_id_write  = reset_n & if_id_c;
   assign bus.if_id_flush  = reset_n & if_flush_c;
   assign bus.id_ex_flush  = reset_n & id_flush_c;
   assign bus.ex_mem_write = reset_n & ex_mem_c;
   assign bus.halted       = halted_q;
   assign bus.stall_cycles = stall_q;
   assign bus.flush_count  = flush_q;
   assign bus.bubble_count = bubble_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: priority table plus freeze, watchdog,
// saturation and reset corner sequences (STALL_LIMIT=4, CNT_W=4).
module tb_pipeline_stall_ctrl;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   pipeline_stall_ctrl_if #(.CNT_W(4)) bus ();

   pipeline_stall_ctrl #(
      .STALL_LIMIT (4),
      .CNT_W       (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // expected controls packed as {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write}
   typedef struct packed {
      logic       mb;
      logic       bt;
      logic       dh;
      logic       jid;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_ctrl(input string name, input logic [4:0] exp);
      check(name, {27'd0, bus.pc_write, bus.if_id_write, bus.if_id_flush,
                   bus.id_ex_flush, bus.ex_mem_write}, {27'd0, exp});
   endtask

   task automatic check_cnt(input string name, input int s, input int f, input int b);
      check({name, "_stall"},  {28'd0, bus.stall_cycles}, s);
      check({name, "_flush"},  {28'd0, bus.flush_count},  f);
      check({name, "_bubble"}, {28'd0, bus.bubble_count}, b);
   endtask

   task automatic apply(input logic mb, input logic bt, input logic dh, input logic jid,
                        input logic wc, input logic cc);
      bus.mem_busy     = mb;
      bus.branch_taken = bt;
      bus.data_hazard  = dh;
      bus.jump_id      = jid;
      bus.wdog_clear   = wc;
      bus.cnt_clear    = cc;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      vecs = '{
         '{1'b0, 1'b0, 1'b0, 1'b0, 5'b11001},
         '{1'b0, 1'b0, 1'b0, 1'b1, 5'b11101},
         '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00011},
         '{1'b0, 1'b0, 1'b1, 1'b1, 5'b00011},
         '{1'b0, 1'b1, 1'b0, 1'b0, 5'b11111},
         '{1'b0, 1'b1, 1'b0, 1'b1, 5'b11111},
         '{1'b0, 1'b1, 1'b1, 1'b0, 5'b11111},
         '{1'b0, 1'b1, 1'b1, 1'b1, 5'b11111},
         '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00000},
         '{1'b1, 1'b0, 1'b0, 1'b1, 5'b00000},
         '{1'b1, 1'b0, 1'b1, 1'b0, 5'b00000},
         '{1'b1, 1'b0, 1'b1, 1'b1, 5'b00000},
         '{1'b1, 1'b1, 1'b0, 1'b0, 5'b00000},
         '{1'b1, 1'b1, 1'b0, 1'b1, 5'b00000},
         '{1'b1, 1'b1, 1'b1, 1'b0, 5'b00000},
         '{1'b1, 1'b1, 1'b1, 1'b1, 5'b00000}
      };

      // Reset with a jump pending: no enable and no flush may leak out.
      reset_n = 1'b0;
      apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check_ctrl("reset_ctrl", 5'b00000);
      check("reset_halted", {31'd0, bus.halted}, 32'd0);
      check_cnt("reset", 0, 0, 0);
      tick;
      reset_n = 1'b1;

      // Priority table; wdog_clear keeps the watchdog quiet, cnt_clear keeps counters at zero.
      for (int i = 0; i < 16; i++) begin
         apply(vecs[i].mb, vecs[i].bt, vecs[i].dh, vecs[i].jid, 1'b1, 1'b1);
         check_ctrl($sformatf("vec%0d", i), vecs[i].exp);
         tick;
      end
      check("table_halted", {31'd0, bus.halted}, 32'd0);

      // Single data-hazard bubble.
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick;
      check_cnt("clr", 0, 0, 0);
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctrl("dh_bubble", 5'b00011);
      tick;
      check_cnt("dh", 1, 1, 1);

      // Taken branch overrides a simultaneous data hazard.
      apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctrl("bt_over_dh", 5'b11111);
      tick;
      check_cnt("bt", 1, 2, 1);

      // Three memory-wait cycles, then the held hazard is resolved as mem_busy drops.
      for (int k = 0; k < 3; k++) begin
         apply(1'b1, 1'b0, 1'b1, 1'b0, (k == 0), 1'b0);
         check_ctrl($sformatf("freeze%0d", k), 5'b00000);
         tick;
      end
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctrl("freeze_exit_bubble", 5'b00011);
      tick;
      check_cnt("freeze", 5, 3, 2);
      check("freeze_halted", {31'd0, bus.halted}, 32'd0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_ctrl("run_after_freeze", 5'b11001);
      tick;

      // Watchdog: four consecutive stalls trip HALT on the fifth cycle.
      for (int k = 0; k < 4; k++) begin
         apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         check_ctrl($sformatf("wd_stall%0d", k), 5'b00011);
         tick;
         if (k < 3) check($sformatf("wd_pre_halt%0d", k), {31'd0, bus.halted}, 32'd0);
      end
      check("wd_halted", {31'd0, bus.halted}, 32'd1);
      check_cnt("wd", 9, 7, 6);
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctrl("halt_ctrl", 5'b00000);
      tick;
      check_cnt("halt_frozen", 9, 7, 6);
      check("halt_hold", {31'd0, bus.halted}, 32'd1);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_ctrl("halt_clear_ctrl", 5'b00000);
      tick;
      check("halt_released", {31'd0, bus.halted}, 32'd0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_ctrl("run_after_halt", 5'b11001);
      tick;

      // Counter saturation at 15, then clear beats a same-cycle increment.
      for (int k = 0; k < 20; k++) begin
         apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
         tick;
      end
      check_cnt("sat", 15, 15, 15);
      check("sat_halted", {31'd0, bus.halted}, 32'd0);
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick;
      check_cnt("clr_wins", 0, 0, 0);

      // Reset asserted while frozen on a memory wait.
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick;
      check_cnt("pre_rst", 1, 0, 0);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b0;
      #1;
      check_ctrl("rst_freeze_ctrl", 5'b00000);
      check_cnt("rst_freeze", 0, 0, 0);
      check("rst_freeze_halted", {31'd0, bus.halted}, 32'd0);
      tick;
      reset_n = 1'b1;
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_ctrl("post_rst_run", 5'b11001);
      tick;
      check_cnt("post_rst", 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
